// File: rtl/audio_synth_wb.sv
// audio_synth_wb: N_CH phase-accumulator tone generators configured over Wishbone.
// A single adder mixes the channels into MSB-aligned stereo samples behind a valid/ack handshake.
module audio_synth_wb #(
    parameter int N_CH = 2,
    parameter int AW   = 20,
    parameter int OW   = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [4:0]    wb_addr,
    input  logic [31:0]   wb_wdata,
    output logic [31:0]   wb_rdata,
    input  logic          wb_we,
    input  logic          wb_cyc,
    output logic          wb_ack,
    output logic [OW-1:0] audio_l,
    output logic [OW-1:0] audio_r,
    output logic          valid,
    input  logic          ack
);

    localparam int ACC_W = (N_CH == 1) ? 16 : 16 + $clog2(N_CH);
    localparam int SW    = (N_CH > 1) ? $clog2(N_CH) : 1;

    // Handshake: valid is high only in HOLD, and audio_l/r then carry a finished mix.
    // The sample is consumed on a cycle with valid & ack; ack outside HOLD is dropped, never queued.
    typedef enum logic [1:0] {S_IDLE, S_MIX, S_LOAD, S_HOLD} state_t;

    state_t                  r_state, w_state_nxt;
    logic [SW-1:0]           r_slot;
    logic                    r_wb_ack;
    logic [1:0]              r_mode  [N_CH];
    logic [3:0]              r_vol   [N_CH];
    logic                    r_pan_l [N_CH];
    logic                    r_pan_r [N_CH];
    logic [AW-1:0]           r_step  [N_CH];
    logic [AW-1:0]           r_phase [N_CH];
    logic signed [ACC_W-1:0] r_acc_l, r_acc_r;
    logic [OW-1:0]           r_audio_l, r_audio_r;

    logic                    w_wr, w_last, w_first, w_pl, w_pr, w_unused;
    logic [N_CH-1:0]         w_clr;
    logic [31:0]             w_rd;
    logic [1:0]              w_mode;
    logic [3:0]              w_vol;
    logic [AW-1:0]           w_p;
    logic [15:0]             w_tri_u;
    logic signed [15:0]      w_s, w_v;
    logic signed [ACC_W-1:0] w_v_ext, w_acc_l_nxt, w_acc_r_nxt;

    assign w_wr     = wb_cyc & wb_we & r_wb_ack;
    assign w_last   = (r_slot == SW'(N_CH - 1));
    assign w_first  = (r_slot == '0);
    assign w_unused = ^wb_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_slot   <= '0;
            r_wb_ack <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_slot   <= (r_state == S_MIX && !w_last) ? r_slot + SW'(1) : '0;
            r_wb_ack <= wb_cyc & ~r_wb_ack;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_MIX;
            S_MIX:   if (w_last) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_HOLD;
            S_HOLD:  if (ack) w_state_nxt = S_MIX;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_clr = '0;
        w_rd  = '0;
        for (int c = 0; c < N_CH; c++) begin
            w_clr[c] = w_wr && (wb_addr == 5'(2 * c)) && wb_wdata[31];
            if (wb_addr == 5'(2 * c))
                w_rd = {22'b0, r_pan_r[c], r_pan_l[c], r_vol[c], 2'b00, r_mode[c]};
            if (wb_addr == 5'(2 * c + 1))
                w_rd = 32'(r_step[c]);
        end
    end

    assign wb_ack   = r_wb_ack;
    assign wb_rdata = r_wb_ack ? w_rd : '0;

    // Phase clear from a CTRL write takes priority over that channel's advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                r_mode[c]  <= '0;
                r_vol[c]   <= '0;
                r_pan_l[c] <= 1'b0;
                r_pan_r[c] <= 1'b0;
                r_step[c]  <= '0;
                r_phase[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (w_wr && wb_addr == 5'(2 * c)) begin
                    r_mode[c]  <= wb_wdata[1:0];
                    r_vol[c]   <= wb_wdata[7:4];
                    r_pan_l[c] <= wb_wdata[8];
                    r_pan_r[c] <= wb_wdata[9];
                end
                if (w_wr && wb_addr == 5'(2 * c + 1))
                    r_step[c] <= wb_wdata[AW-1:0];
                if (w_clr[c])
                    r_phase[c] <= '0;
                else if (r_state == S_MIX && r_slot == SW'(c) && r_mode[c] != 2'd0)
                    r_phase[c] <= r_phase[c] + r_step[c];
            end
        end
    end

    always_comb begin
        w_mode = '0;
        w_vol  = '0;
        w_pl   = 1'b0;
        w_pr   = 1'b0;
        w_p    = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (r_slot == SW'(c)) begin
                w_mode = r_mode[c];
                w_vol  = r_vol[c];
                w_pl   = r_pan_l[c];
                w_pr   = r_pan_r[c];
                w_p    = r_phase[c];
            end
        end
    end

    always_comb begin
        w_s     = '0;
        w_tri_u = w_p[AW-1] ? ~w_p[AW-2:AW-17] : w_p[AW-2:AW-17];
        case (w_mode)
            2'd1:    w_s = w_p[AW-1:AW-16] ^ 16'h8000;
            2'd2:    w_s = w_tri_u ^ 16'h8000;
            2'd3:    w_s = w_p[AW-1] ? 16'h8000 : 16'h7FFF;
            default: w_s = '0;
        endcase
    end

    assign w_v         = w_s >>> w_vol;
    assign w_v_ext     = ACC_W'(w_v);
    assign w_acc_l_nxt = (w_first ? '0 : r_acc_l) + (w_pl ? w_v_ext : '0);
    assign w_acc_r_nxt = (w_first ? '0 : r_acc_r) + (w_pr ? w_v_ext : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_l   <= '0;
            r_acc_r   <= '0;
            r_audio_l <= '0;
            r_audio_r <= '0;
        end else begin
            if (r_state == S_MIX) begin
                r_acc_l <= w_acc_l_nxt;
                r_acc_r <= w_acc_r_nxt;
            end
            if (r_state == S_LOAD) begin
                r_audio_l <= OW'(r_acc_l) <<< (OW - ACC_W);
                r_audio_r <= OW'(r_acc_r) <<< (OW - ACC_W);
            end
        end
    end

    assign valid   = (r_state == S_HOLD);
    assign audio_l = r_audio_l;
    assign audio_r = r_audio_r;

endmodule

// File: tb/tb_audio_synth_wb.sv
// Directed bench for audio_synth_wb: Wishbone configuration, saw/square mixing, handshake
// timing, phase clear, unmapped addresses and asynchronous reset during a mix.
module tb_audio_synth_wb;

    localparam int N_CH = 2;
    localparam int AW   = 20;
    localparam int OW   = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    wb_addr;
    logic [31:0]   wb_wdata;
    logic [31:0]   wb_rdata;
    logic          wb_we;
    logic          wb_cyc;
    logic          wb_ack;
    logic [OW-1:0] audio_l;
    logic [OW-1:0] audio_r;
    logic          valid;
    logic          ack;

    audio_synth_wb #(.N_CH(N_CH), .AW(AW), .OW(OW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_addr  (wb_addr),
        .wb_wdata (wb_wdata),
        .wb_rdata (wb_rdata),
        .wb_we    (wb_we),
        .wb_cyc   (wb_cyc),
        .wb_ack   (wb_ack),
        .audio_l  (audio_l),
        .audio_r  (audio_r),
        .valid    (valid),
        .ack      (ack)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;
    int n_fail = 0;

    logic [OW-1:0] exp_l_q[$];
    logic [OW-1:0] exp_r_q[$];

    // reference model state, updated from the bus writes the bench issues
    logic [1:0]    m_mode [N_CH];
    logic [3:0]    m_vol  [N_CH];
    logic          m_pl   [N_CH];
    logic          m_pr   [N_CH];
    logic [AW-1:0] m_step [N_CH];
    logic [AW-1:0] m_ph   [N_CH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int ch_val(input logic [1:0] mode, input logic [3:0] vol,
                                  input logic [AW-1:0] p);
        int s;
        logic [15:0] u;
        s = 0;
        u = p[19] ? ~p[18:3] : p[18:3];
        case (mode)
            2'd1:    s = int'(p[19:4]) - 32768;
            2'd2:    s = int'(u) - 32768;
            2'd3:    s = p[19] ? -32768 : 32767;
            default: s = 0;
        endcase
        return s >>> vol;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_mode[c] = '0; m_vol[c] = '0; m_pl[c] = 1'b0; m_pr[c] = 1'b0;
            m_step[c] = '0; m_ph[c]  = '0;
        end
    endtask

    task automatic push_next();
        int sl, sr, v;
        sl = 0;
        sr = 0;
        for (int c = 0; c < N_CH; c++) begin
            v = ch_val(m_mode[c], m_vol[c], m_ph[c]);
            if (m_pl[c]) sl += v;
            if (m_pr[c]) sr += v;
            if (m_mode[c] != 2'd0) m_ph[c] = m_ph[c] + m_step[c];
        end
        exp_l_q.push_back(OW'(sl * 128));
        exp_r_q.push_back(OW'(sr * 128));
    endtask

    task automatic pop_compare(input string tag);
        logic [OW-1:0] el, er;
        el = exp_l_q.pop_front();
        er = exp_r_q.pop_front();
        chk({tag, "_l"}, 32'(audio_l), 32'(el));
        chk({tag, "_r"}, 32'(audio_r), 32'(er));
    endtask

    task automatic wait_sample(input string tag);
        int t;
        t = 0;
        while (valid !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        pop_compare(tag);
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic wb_xfer(input logic [4:0] a, input logic we, input logic [31:0] d,
                           output logic [31:0] rd);
        @(negedge clk);
        wb_addr  = a;
        wb_we    = we;
        wb_wdata = d;
        wb_cyc   = 1'b1;
        @(posedge clk);
        #1;
        chk("wb_ack_1cyc", 32'(wb_ack), 32'd1);
        rd = wb_rdata;
        @(posedge clk);
        @(negedge clk);
        wb_cyc = 1'b0;
        wb_we  = 1'b0;
    endtask

    task automatic wb_read(input logic [4:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] rd;
        wb_xfer(a, 1'b0, 32'd0, rd);
        chk(tag, rd, exp);
    endtask

    task automatic cfg_ctrl(input int c, input logic [31:0] d);
        logic [31:0] rd;
        wb_xfer(5'(2 * c), 1'b1, d, rd);
        m_mode[c] = d[1:0];
        m_vol[c]  = d[7:4];
        m_pl[c]   = d[8];
        m_pr[c]   = d[9];
        if (d[31]) m_ph[c] = '0;
    endtask

    task automatic cfg_step(input int c, input logic [31:0] d);
        logic [31:0] rd;
        wb_xfer(5'(2 * c + 1), 1'b1, d, rd);
        m_step[c] = d[AW-1:0];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [31:0] rd;
        rst_n = 1'b0; wb_addr = '0; wb_wdata = '0; wb_we = 1'b0; wb_cyc = 1'b0; ack = 1'b0;
        model_reset();

        // reset values, then first sample with no ack needed
        repeat (3) @(negedge clk);
        chk("rst_valid",    32'(valid),   32'd0);
        chk("rst_audio_l",  32'(audio_l), 32'd0);
        chk("rst_audio_r",  32'(audio_r), 32'd0);
        chk("rst_wb_ack",   32'(wb_ack),  32'd0);
        chk("rst_wb_rdata", wb_rdata,     32'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("valid_3rd_clk", 32'(valid), 32'd0);
        @(negedge clk);
        chk("valid_4th_clk", 32'(valid), 32'd1);
        push_next();
        pop_compare("first");

        // ch0 saw on the left, through a full phase wrap
        cfg_step(0, 32'h0001_0000);
        cfg_ctrl(0, 32'h0000_0101);
        wb_read(5'd0, 32'h0000_0101, "rd_ctrl0");
        wb_read(5'd1, 32'h0001_0000, "rd_step0");
        for (int k = 0; k < 17; k++) begin
            push_next();
            ack_pulse();
            wait_sample($sformatf("saw%0d", k));
        end

        // ch1 square, vol 2, both sides; ch0 off
        cfg_ctrl(0, 32'h0000_0000);
        cfg_step(1, 32'h0004_0000);
        cfg_ctrl(1, 32'h0000_0323);
        wb_read(5'd2, 32'h0000_0323, "rd_ctrl1");
        for (int k = 0; k < 5; k++) begin
            push_next();
            ack_pulse();
            wait_sample($sformatf("sq%0d", k));
        end

        // ack held high: one sample every N_CH+2 cycles
        for (int k = 0; k < 10; k++) push_next();
        cnt = 0;
        ack = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                cnt++;
                pop_compare($sformatf("held%0d", cnt));
            end
        end
        ack = 1'b0;
        chk("held_count", 32'(cnt), 32'd10);

        // ack kept high through MIX and LOAD yields exactly one new sample
        push_next();
        ack = 1'b1;
        repeat (3) @(negedge clk);
        ack = 1'b0;
        wait_sample("mixpulse");
        repeat (5) @(negedge clk);
        chk("no_extra_sample", 32'(valid), 32'd1);

        // phase clear mid-stream restarts ch0 saw at phase 0
        cfg_ctrl(1, 32'h0000_0000);
        cfg_ctrl(0, 32'h8000_0101);
        wb_read(5'd0, 32'h0000_0101, "rd_ctrl0_clr");
        for (int k = 0; k < 2; k++) begin
            push_next();
            ack_pulse();
            wait_sample($sformatf("clr%0d", k));
        end

        // unmapped addresses read zero, writes there are ignored
        wb_xfer(5'd4, 1'b1, 32'hFFFF_FFFF, rd);
        wb_read(5'd4,  32'd0, "rd_addr4");
        wb_read(5'd5,  32'd0, "rd_addr5");
        wb_read(5'd31, 32'd0, "rd_addr31");

        // async reset during MIX
        ack = 1'b1;
        @(posedge clk);
        #2;
        ack   = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midmix_valid",   32'(valid),   32'd0);
        chk("midmix_audio_l", 32'(audio_l), 32'd0);
        chk("midmix_audio_r", 32'(audio_r), 32'd0);
        model_reset();
        exp_l_q.delete();
        exp_r_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rerst_valid_3rd", 32'(valid), 32'd0);
        @(negedge clk);
        chk("rerst_valid_4th", 32'(valid), 32'd1);
        push_next();
        pop_compare("rerst");
        wb_read(5'd0, 32'd0, "rd_ctrl0_rerst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
